if_fetch_unit: RTL and testbench
================================

# if_fetch_unit

Instruction-fetch stage: owns the program counter, issues single-outstanding requests to the instruction memory, and loads the IF/ID pipeline register. It sits directly downstream of the hazard detection unit. It consumes `stall_IF`, `flush_IF`, `NPCOp_out`, `NPCImm_out` and `base_PC_out` from that unit, plus `alu_result_EX`, and feeds `PC_ID`, `instr_ID` and `valid_ID` to the decode stage.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value after reset.
- `NOP_INSTR`, default 32'h0000_0013: bubble encoding (`addi x0,x0,0`).
- `clk`, input, 1: sole clock, rising edge.
- `rst`, input, 1: reset, synchronous, active-high.
- `stall_IF`, input, 1: hold PC and IF/ID.
- `flush_IF`, input, 1: squash the instruction in IF and in flight.
- `NPCOp_in`, input, 3: `NPC_PLUS4` / `NPC_BRANCH` / `NPC_JUMP` / `NPC_JALR`.
- `NPCImm_in`, input, 32: redirect offset.
- `base_PC_in`, input, 32: redirect base PC.
- `alu_result_EX`, input, 32: JALR target.
- `imem_req`, output, 1: fetch request.
- `imem_addr`, output, 32: fetch address, word aligned.
- `imem_gnt`, input, 1: request accepted this cycle.
- `imem_rvalid`, input, 1: response data valid.
- `imem_rdata`, input, 32: fetched instruction.
- `PC_ID`, output, 32: PC of the IF/ID instruction.
- `instr_ID`, output, 32: IF/ID instruction.
- `valid_ID`, output, 1: IF/ID holds a real instruction.
- `misalign_ID`, output, 1: only with `IF_MISALIGN_CHECK_EN`.

## Operation
- **Redirect:** redirect = `NPCOp_in != NPC_PLUS4`. The target is:
  - `base_PC_in + NPCImm_in` for BRANCH and JUMP.
  - `alu_result_EX & ~32'h1` for JALR.
  - All arithmetic is 32-bit modulo. 32'hFFFF_FFFC + 4 wraps to 0.
- **States:**
  - S_BOOT: one cycle after reset, no request.
  - S_REQ: `imem_req=1`, `imem_addr=pc_q`.
  - S_WAIT: one request outstanding.
  - S_HOLD: a response is buffered while stalled.
- **Transitions:**
  - S_BOOT → S_REQ.
  - S_REQ with gnt → S_WAIT. Latch `fetch_pc_q=pc_q` and `pc_q+=4`.
  - S_WAIT with rvalid and accepted:
    - Deliver to IF/ID.
    - Back-to-back issue: `imem_req` asserts in the same cycle with `imem_addr=pc_q`. With gnt, stay in S_WAIT; otherwise go to S_REQ.
  - S_WAIT with rvalid while `stall_IF` → S_HOLD. Capture rdata and `fetch_pc_q` in the hold buffer.
  - S_HOLD when `!stall_IF` → deliver the buffer and go to S_REQ.
- **Kill:**
  - A redirect or `flush_IF` while a request is outstanding sets `kill_q`.
  - The next rvalid is discarded and clears `kill_q`.
  - A redirect in S_HOLD drops the buffer.
  - In all cases `pc_q` is loaded with the target (not for a bare `flush_IF`), and the FSM goes to S_REQ or stays in S_WAIT.
- **`imem_addr` stability:** held stable while `imem_req` is high without gnt, except that a redirect replaces it from the next cycle.
- **IF/ID priority:** `rst` > `flush_IF` (load bubble) > `stall_IF` (hold) > deliver (`valid_ID=1`) > bubble (`valid_ID=0`, `instr_ID=NOP_INSTR`, `PC_ID` unchanged).
- **Redirect vs. stall:** a redirect overrides `stall_IF` for `pc_q`. It never coexists with `stall_IF` in practice, but the behaviour is defined regardless.
- **`imem_addr[1:0]`:** always 2'b00.

## Timing
- **Reset values:**
  - `pc_q=RESET_PC`, state S_BOOT, `kill_q=0`.
  - `imem_req=0`, `imem_addr=RESET_PC`.
  - `PC_ID=0`, `instr_ID=NOP_INSTR`, `valid_ID=0`, `misalign_ID=0`.
- **Reset mid-transaction:** pending responses are ignored until the first post-reset gnt. The memory side must also be reset.
- **Latency:**
  - First `imem_req` occurs in cycle 2 after `rst` deasserts.
  - With a zero-wait memory (gnt same cycle, rvalid next cycle), `instr_ID` is updated one edge after rvalid.
  - Steady-state throughput is one instruction per cycle.
- **Redirect:** a redirect in cycle N puts the target on `imem_addr` in cycle N+1.

## Configuration
- **`IF_MISALIGN_CHECK_EN` defined:**
  - A BRANCH or JUMP target with `target[1]=1` is fetched at `target & ~3`.
  - The delivered IF/ID entry carries `misalign_ID=1`.
  - `misalign_ID` clears with the next delivered instruction.
- **Not defined:** the port is absent and targets are silently word-aligned.

## Structure
- **Shared package / header:** `NPC_*` and `OPCODE_*` codes, `NOP_INSTR`, and the state encoding (`FETCH_S_BOOT`/`REQ`/`WAIT`/`HOLD`, 2 bits).
- **Sub-module `if_id_reg`:** the pipeline register with rst/flush/stall/load priority.
- **Top module:** FSM, PC, kill flag, hold buffer.

## Test plan
- **Reset, zero-wait memory:** `imem_addr` sequence 0, 4, 8. `valid_ID` goes high 3 cycles after `rst` drops. `PC_ID`=0, 4, 8 on consecutive cycles.
- **Branch:** `NPCOp_in=NPC_BRANCH`, base 32'h20, imm 32'h40, with `flush_IF`. Next `imem_addr`=32'h60. The in-flight response is discarded (`valid_ID=0` that cycle). `PC_ID`=32'h60 two cycles later.
- **JALR:** `alu_result_EX=32'h105`. `imem_addr`=32'h104.
- **Stall:** `stall_IF` high 3 cycles while rvalid arrives. S_HOLD entered. `instr_ID` unchanged. The buffered instruction appears the cycle after release; none lost or duplicated.
- **gnt withheld:** 4 cycles with a redirect in cycle 2. `imem_addr` is stable in cycle 1, then equals the target from cycle 3.
- **Wrap:** `RESET_PC`=32'hFFFF_FFFC. Second `imem_addr`=0.

Source files
------------

// File: rtl/if_fetch_unit_pkg.sv
// if_fetch_unit_pkg: shared NPC/opcode codes, bubble encoding and fetch FSM states
package if_fetch_unit_pkg;
  localparam logic [2:0] NPC_PLUS4 = 3'd0;
  localparam logic [2:0] NPC_BRANCH = 3'd1;
  localparam logic [2:0] NPC_JUMP = 3'd2;
  localparam logic [2:0] NPC_JALR = 3'd3;
  localparam logic [6:0] OPCODE_LOAD = 7'h03;
  localparam logic [6:0] OPCODE_OP_IMM = 7'h13;
  localparam logic [6:0] OPCODE_AUIPC = 7'h17;
  localparam logic [6:0] OPCODE_STORE = 7'h23;
  localparam logic [6:0] OPCODE_OP = 7'h33;
  localparam logic [6:0] OPCODE_LUI = 7'h37;
  localparam logic [6:0] OPCODE_BRANCH = 7'h63;
  localparam logic [6:0] OPCODE_JALR = 7'h67;
  localparam logic [6:0] OPCODE_JAL = 7'h6f;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  typedef enum logic [1:0] {FETCH_S_BOOT, FETCH_S_REQ, FETCH_S_WAIT, FETCH_S_HOLD} fetch_state_e;
  function automatic logic [31:0] npc_target(input logic [2:0] op, input logic [31:0] base,
                                             input logic [31:0] imm, input logic [31:0] alu);
    return op == NPC_JALR ? alu & ~32'h1 : base + imm;
  endfunction
endpackage

// File: rtl/if_fetch_unit_if_id_reg.sv
// if_id_reg: IF/ID pipeline register, priority rst > flush > stall > load > bubble
module if_id_reg #(
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        stall,
  input  logic        load,
  input  logic [31:0] pc_in,
  input  logic [31:0] instr_in,
  output logic [31:0] pc,
  output logic [31:0] instr,
  output logic        valid
);
  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= 32'h0;
      instr <= NOP_INSTR;
      valid <= 1'b0;
    end else if (flush || (!stall && !load)) begin
      instr <= NOP_INSTR;
      valid <= 1'b0;
    end else if (!stall) begin
      pc <= pc_in;
      instr <= instr_in;
      valid <= 1'b1;
    end
  end
endmodule

// File: rtl/if_fetch_unit.sv
// if_fetch_unit: PC, single-outstanding imem fetch FSM, kill flag and stall hold buffer
// Optional IF_MISALIGN_CHECK_EN adds misalign_ID for half-word BRANCH/JUMP targets.
module if_fetch_unit
  import if_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = if_fetch_unit_pkg::NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_IF,
  input  logic        flush_IF,
  input  logic [2:0]  NPCOp_in,
  input  logic [31:0] NPCImm_in,
  input  logic [31:0] base_PC_in,
  input  logic [31:0] alu_result_EX,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] PC_ID,
  output logic [31:0] instr_ID,
  output logic        valid_ID
`ifdef IF_MISALIGN_CHECK_EN
  ,
  output logic        misalign_ID
`endif
);
  fetch_state_e state_q, state_d;
  logic [31:0] pc_q, pc_d, fetch_pc_q, hold_pc_q, hold_instr_q, target_raw, target;
  logic kill_q, kill_d, redirect, kill_evt, rsp, consume, to_hold, fire, load;
  assign redirect = NPCOp_in != NPC_PLUS4;
  assign kill_evt = redirect || flush_IF;
  assign target_raw = npc_target(NPCOp_in, base_PC_in, NPCImm_in, alu_result_EX);
  assign target = target_raw & ~32'h3;
  assign rsp = state_q == FETCH_S_WAIT && imem_rvalid;
  // a response is consumed unless it must be parked because IF/ID is stalled
  assign consume = rsp && (kill_q || kill_evt || !stall_IF);
  assign to_hold = rsp && !consume;
  assign imem_req = state_q == FETCH_S_REQ || (consume && !kill_evt);
  assign imem_addr = {pc_q[31:2], 2'b00};
  assign fire = imem_req && imem_gnt;
  assign load = !redirect && !stall_IF && ((rsp && !kill_q) || state_q == FETCH_S_HOLD);
  assign pc_d = redirect ? target : fire ? imem_addr + 32'd4 : pc_q;
  always_comb begin
    state_d = state_q;
    kill_d = kill_q;
    case (state_q)
      FETCH_S_BOOT: state_d = FETCH_S_REQ;
      FETCH_S_REQ: begin
        state_d = fire ? FETCH_S_WAIT : FETCH_S_REQ;
        kill_d = fire && kill_evt;
      end
      FETCH_S_WAIT: begin
        state_d = to_hold ? FETCH_S_HOLD : (consume && !fire) ? FETCH_S_REQ : FETCH_S_WAIT;
        kill_d = rsp ? 1'b0 : kill_q || kill_evt;
      end
      FETCH_S_HOLD: state_d = (kill_evt || !stall_IF) ? FETCH_S_REQ : FETCH_S_HOLD;
      default: state_d = FETCH_S_BOOT;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FETCH_S_BOOT;
      pc_q <= RESET_PC;
      kill_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      kill_q <= kill_d;
    end
  end
  always_ff @(posedge clk) begin
    if (fire) fetch_pc_q <= imem_addr;
    if (to_hold) begin
      hold_pc_q <= fetch_pc_q;
      hold_instr_q <= imem_rdata;
    end
  end
  if_id_reg #(.NOP_INSTR(NOP_INSTR)) u_if_id (
    .clk(clk),
    .rst(rst),
    .flush(flush_IF),
    .stall(stall_IF),
    .load(load),
    .pc_in(state_q == FETCH_S_HOLD ? hold_pc_q : fetch_pc_q),
    .instr_in(state_q == FETCH_S_HOLD ? hold_instr_q : imem_rdata),
    .pc(PC_ID),
    .instr(instr_ID),
    .valid(valid_ID)
  );
`ifdef IF_MISALIGN_CHECK_EN
  logic pc_mis_q, fetch_mis_q, hold_mis_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_mis_q <= 1'b0;
      misalign_ID <= 1'b0;
    end else begin
      pc_mis_q <= redirect ? NPCOp_in != NPC_JALR && target_raw[1] : !fire && pc_mis_q;
      if (flush_IF) misalign_ID <= 1'b0;
      else if (load) misalign_ID <= state_q == FETCH_S_HOLD ? hold_mis_q : fetch_mis_q;
    end
    if (fire) fetch_mis_q <= pc_mis_q;
    if (to_hold) hold_mis_q <= fetch_mis_q;
  end
`endif
endmodule

// File: tb/tb_if_fetch_unit.sv
// tb_if_fetch_unit: directed checks of fetch sequencing, redirects, stall hold and PC wrap
module tb_if_fetch_unit;
  import if_fetch_unit_pkg::*;
  logic clk = 1'b0;
  logic rst, stall_IF, flush_IF, gnt_en;
  logic [2:0] NPCOp_in;
  logic [31:0] NPCImm_in, base_PC_in, alu_result_EX;
  logic imem_req, imem_gnt, imem_rvalid, valid_ID;
  logic [31:0] imem_addr, imem_rdata, PC_ID, instr_ID;
  logic w_req, w_rvalid, w_valid;
  logic [31:0] w_addr, w_pc, w_instr;
  int n_cmp = 0, n_err = 0;
  always #5 clk = ~clk;
  function automatic logic [31:0] f(input logic [31:0] a);
    return a ^ 32'h5A5A_0003;
  endfunction
  assign imem_gnt = imem_req && gnt_en;
  always @(posedge clk) begin
    imem_rvalid <= !rst && imem_req && imem_gnt;
    if (imem_req && imem_gnt) imem_rdata <= f(imem_addr);
    w_rvalid <= !rst && w_req;
  end
  if_fetch_unit dut (
    .clk(clk), .rst(rst), .stall_IF(stall_IF), .flush_IF(flush_IF),
    .NPCOp_in(NPCOp_in), .NPCImm_in(NPCImm_in), .base_PC_in(base_PC_in),
    .alu_result_EX(alu_result_EX), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .PC_ID(PC_ID), .instr_ID(instr_ID), .valid_ID(valid_ID)
  );
  if_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
    .clk(clk), .rst(rst), .stall_IF(1'b0), .flush_IF(1'b0),
    .NPCOp_in(NPC_PLUS4), .NPCImm_in(32'h0), .base_PC_in(32'h0),
    .alu_result_EX(32'h0), .imem_req(w_req), .imem_addr(w_addr),
    .imem_gnt(w_req), .imem_rvalid(w_rvalid), .imem_rdata(32'h0),
    .PC_ID(w_pc), .instr_ID(w_instr), .valid_ID(w_valid)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic cyc();
    @(negedge clk);
  endtask
  task automatic idle();
    NPCOp_in = NPC_PLUS4;
    flush_IF = 1'b0;
  endtask
  initial begin
    rst = 1'b1; stall_IF = 1'b0; gnt_en = 1'b1; idle();
    NPCImm_in = 32'h0; base_PC_in = 32'h0; alu_result_EX = 32'h0;
    repeat (3) cyc();
    #1;
    chk("rst_req", imem_req, 0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_pc_id", PC_ID, 32'h0);
    chk("rst_instr", instr_ID, NOP_INSTR);
    chk("rst_valid", valid_ID, 0);
    chk("rst_wrap_addr", w_addr, 32'hFFFF_FFFC);
    rst = 1'b0;
    #1 chk("boot_req", imem_req, 0);
    cyc(); #1;
    chk("n1_req", imem_req, 1);
    chk("n1_addr", imem_addr, 32'h0);
    chk("n1_valid", valid_ID, 0);
    chk("wrap_addr1", w_addr, 32'hFFFF_FFFC);
    cyc(); #1;
    chk("n2_addr", imem_addr, 32'h4);
    chk("n2_valid", valid_ID, 0);
    chk("wrap_addr2", w_addr, 32'h0);
    cyc(); #1;
    chk("n3_valid", valid_ID, 1);
    chk("n3_pc", PC_ID, 32'h0);
    chk("n3_instr", instr_ID, f(32'h0));
    chk("n3_addr", imem_addr, 32'h8);
    cyc(); #1;
    chk("n4_pc", PC_ID, 32'h4);
    chk("n4_instr", instr_ID, f(32'h4));
    cyc();
    chk("n5_pc", PC_ID, 32'h8);
    NPCOp_in = NPC_BRANCH; base_PC_in = 32'h20; NPCImm_in = 32'h40; flush_IF = 1'b1;
    cyc(); idle(); #1;
    chk("br_addr", imem_addr, 32'h60);
    chk("br_req", imem_req, 1);
    chk("br_squash", valid_ID, 0);
    cyc(); #1;
    chk("br_bubble", valid_ID, 0);
    cyc();
    chk("br_pc", PC_ID, 32'h60);
    chk("br_valid", valid_ID, 1);
    NPCOp_in = NPC_JALR; alu_result_EX = 32'h105;
    cyc(); idle(); #1;
    chk("jalr_addr", imem_addr, 32'h104);
    chk("jalr_valid", valid_ID, 0);
    cyc();
    cyc();
    chk("jalr_pc", PC_ID, 32'h104);
    chk("jalr_instr", instr_ID, f(32'h104));
    stall_IF = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      if (i == 2) stall_IF = 1'b0;
      #1;
      chk("stall_instr", instr_ID, f(32'h104));
      chk("stall_pc", PC_ID, 32'h104);
      if (i == 0) chk("hold_req", imem_req, 0);
    end
    cyc(); #1;
    chk("rel_pc", PC_ID, 32'h108);
    chk("rel_instr", instr_ID, f(32'h108));
    chk("rel_addr", imem_addr, 32'h10C);
    cyc(); #1;
    chk("rel_bubble", valid_ID, 0);
    chk("rel_bubble_pc", PC_ID, 32'h108);
    cyc();
    chk("rel_next_pc", PC_ID, 32'h10C);
    gnt_en = 1'b0;
    #1;
    chk("ng_addr1", imem_addr, 32'h114);
    chk("ng_req1", imem_req, 1);
    cyc();
    chk("ng_pc", PC_ID, 32'h110);
    NPCOp_in = NPC_JUMP; base_PC_in = 32'h200; NPCImm_in = 32'h10;
    #1 chk("ng_addr2", imem_addr, 32'h114);
    cyc(); idle(); #1;
    chk("ng_addr3", imem_addr, 32'h210);
    cyc(); #1;
    chk("ng_addr4", imem_addr, 32'h210);
    cyc(); gnt_en = 1'b1; #1;
    chk("ng_addr5", imem_addr, 32'h210);
    chk("ng_req5", imem_req, 1);
    cyc();
    cyc();
    chk("jmp_pc", PC_ID, 32'h210);
    chk("jmp_valid", valid_ID, 1);
    gnt_en = 1'b0;
    cyc();
    chk("kill_pre_pc", PC_ID, 32'h214);
    gnt_en = 1'b1; NPCOp_in = NPC_BRANCH; base_PC_in = 32'h300; NPCImm_in = 32'h0;
    #1 chk("kill_req_addr", imem_addr, 32'h218);
    cyc(); idle(); #1;
    chk("kill_reissue_req", imem_req, 1);
    chk("kill_reissue_addr", imem_addr, 32'h300);
    cyc(); #1;
    chk("kill_discard", valid_ID, 0);
    cyc(); #1;
    chk("kill_pc", PC_ID, 32'h300);
    chk("kill_instr", instr_ID, f(32'h300));
    chk("kill_valid", valid_ID, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
